// File: rtl/nibble_deser_pkg.sv
// Shared types and constants for the nibble deserializer slice.
package nibble_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_deser_if.sv
// Serial input, word output handshake and status bundle for nibble_deser.
interface nibble_deser_if
  import nibble_pkg::*;
#(
  parameter int unsigned DATA_W = NIBBLE_W
);

  logic              sin;
  logic              sin_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output sin, sin_en, out_ready,
    input  out_data, out_valid, busy, frame_err, parity_err, overrun
  );

  modport slave (
    input  sin, sin_en, out_ready,
    output out_data, out_valid, busy, frame_err, parity_err, overrun
  );

endinterface

// File: rtl/nibble_deser_hold.sv
// One-entry valid/ready holding register; flags a good word that arrives while full.
module nibble_hold
  import nibble_pkg::*;
#(
  parameter int unsigned DATA_W = NIBBLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              xfer_c;

  assign xfer_c = valid_q & ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // A word draining on the same edge frees the slot for the incoming one.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      if (!valid_q || xfer_c) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer_c) begin
      valid_d = 1'b0;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/nibble_deser.sv
// Strobed serial frame receiver: start, LSB-first data, optional even parity, stop.
// Parity stage is built only when NIBBLE_DESER_PARITY_EN is defined.
module nibble_deser
  import nibble_pkg::*;
#(
  parameter int unsigned DATA_W = NIBBLE_W
) (
  input  logic           clk,
  input  logic           rst,
  nibble_deser_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              good_frame_c;
  logic              par_ok_c;

`ifdef NIBBLE_DESER_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign par_ok_c = ~(^{par_q, shreg_q});
`else
  assign par_ok_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Frame sequencer; everything advances only on strobed cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    good_frame_c = 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
    par_d        = par_q;
`endif
    if (bus.sin_en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sin == START_LVL) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d[cnt_q] = bus.sin;
          cnt_d          = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_LAST) begin
`ifdef NIBBLE_DESER_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
        PAR: begin
`ifdef NIBBLE_DESER_PARITY_EN
          par_d   = bus.sin;
          state_d = STOP;
`else
          state_d = IDLE;
`endif
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit masks any parity problem.
          if (bus.sin != STOP_LVL)  frame_err_d  = 1'b1;
          else if (!par_ok_c)       parity_err_d = 1'b1;
          else                      good_frame_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  nibble_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_i    (good_frame_c),
    .data_i    (shreg_q),
    .ready_i   (bus.out_ready),
    .data_o    (bus.out_data),
    .valid_o   (bus.out_valid),
    .overrun_o (bus.overrun)
  );

  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;

endmodule
